// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: two-entry skid buffer between fetch and EX,
// immediate/register-field decode at capture, one-cycle load-use bubble,
// and pipeline flush.
module decode_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic             out_is_load,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        is_load;
    logic        use_rs1;
    logic        use_rs2;
  } entry_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Decode one fetched word into the bundle stored in a buffer entry.
  function automatic entry_t decode(input logic [31:0] i, input logic [31:0] pc);
    entry_t e;
    e         = '0;
    e.pc      = pc;
    e.opcode  = i[6:0];
    e.rd      = i[11:7];
    e.rs1     = i[19:15];
    e.rs2     = i[24:20];
    e.is_load = (i[6:0] == OP_LOAD);
    case (i[6:0])
      OP_LOAD, OP_IMM: begin
        e.imm     = {{20{i[31]}}, i[31:20]};
        e.use_rs1 = 1'b1;
      end
      OP_STORE: begin
        e.imm     = {{20{i[31]}}, i[31:25], i[11:7]};
        e.use_rs1 = 1'b1;
        e.use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        e.imm     = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        e.use_rs1 = 1'b1;
        e.use_rs2 = 1'b1;
      end
      OP_JAL: begin
        e.imm     = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      OP_REG: begin
        e.use_rs1 = 1'b1;
        e.use_rs2 = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Saturating increment: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           new_e;
  logic             lu_pending_q, lu_pending_d;
  logic [4:0]       lu_rd_q, lu_rd_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             hazard, bubble, in_fire, out_fire;

  assign new_e = decode(in_instr, in_pc);

  assign hazard = (main_q.use_rs1 && (main_q.rs1 == lu_rd_q)) ||
                  (main_q.use_rs2 && (main_q.rs2 == lu_rd_q));
  assign bubble = lu_pending_q && (state_q != EMPTY) && hazard;

  // Handshake outputs depend on registered state only.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY) && !bubble;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign out_pc       = main_q.pc;
  assign out_opcode   = main_q.opcode;
  assign out_rd       = main_q.rd;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_imm      = main_q.imm;
  assign out_is_load  = main_q.is_load;
  assign bubble_count = bubble_cnt_q;

  // Next-state: buffer occupancy, entry movement, load-use tracking, flush.
  always_comb begin
    state_d      = state_q;
    main_d       = main_q;
    skid_d       = skid_q;
    lu_pending_d = 1'b0;
    lu_rd_d      = lu_rd_q;
    bubble_cnt_d = bubble ? sat_inc(bubble_cnt_q) : bubble_cnt_q;

    if (out_fire && main_q.is_load && (main_q.rd != 5'd0)) begin
      lu_pending_d = 1'b1;
      lu_rd_d      = main_q.rd;
    end

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = new_e;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = new_e;
        end else if (in_fire) begin
          skid_d  = new_e;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A flush kills both entries and any beat accepted this cycle.
    if (flush) begin
      state_d      = EMPTY;
      lu_pending_d = 1'b0;
    end
  end

  // State register; reset clears payload too so outputs read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      lu_pending_q <= 1'b0;
      lu_rd_q      <= 5'd0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      lu_pending_q <= lu_pending_d;
      lu_rd_q      <= lu_rd_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: stimulus pushes expected bundles,
// a negedge monitor pops and compares every issued bundle.
module tb_decode_issue_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_instr, in_pc, out_pc, out_imm;
  logic [6:0]       out_opcode;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic             out_is_load;
  logic [CNT_W-1:0] bubble_count;

  decode_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_is_load(out_is_load), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every bundle EX accepts must match the head of the queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got pc 0x%08h, required no issue", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc",      out_pc,              e.pc);
        chk("out_imm",     out_imm,             e.imm);
        chk("out_opcode",  {25'd0, out_opcode}, {25'd0, e.instr[6:0]});
        chk("out_rd",      {27'd0, out_rd},     {27'd0, e.instr[11:7]});
        chk("out_rs1",     {27'd0, out_rs1},    {27'd0, e.instr[19:15]});
        chk("out_rs2",     {27'd0, out_rs2},    {27'd0, e.instr[24:20]});
        chk("out_is_load", {31'd0, out_is_load}, {31'd0, (e.instr[6:0] == 7'b0000011)});
      end
    end
  end

  // Offer one beat and wait (bounded) for it to be accepted.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] imm, input bit expect_out);
    int n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (expect_out) begin
      e.instr = instr;
      e.pc    = pc;
      e.imm   = imm;
      exp_q.push_back(e);
    end
  endtask

  // Wait (bounded) until every expected bundle has been issued.
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",    {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",     {31'd0, in_ready},  32'd1);
    chk("rst_out_pc",       out_pc,             32'd0);
    chk("rst_out_imm",      out_imm,            32'd0);
    chk("rst_bubble_count", {16'd0, bubble_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic issue with one-cycle latency
    send(32'h00500093, 32'h100, 32'h5, 1'b1);
    @(negedge clk);
    chk("basic_latency_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // Immediate formats, back-to-back
    send(32'hFE000EE3, 32'h104, 32'hFFFFFFFC, 1'b1);
    send(32'hFF9FF06F, 32'h108, 32'hFFFFFFF8, 1'b1);
    send(32'hFE112E23, 32'h10C, 32'hFFFFFFFC, 1'b1);
    send(32'h000010B7, 32'h110, 32'h0,        1'b1);
    drain();

    // Backpressure: two beats fill the buffer, the third waits
    out_ready = 1'b0;
    send(32'h00500093, 32'h200, 32'h5, 1'b1);
    send(32'h00A00113, 32'h204, 32'hA, 1'b1);
    in_valid = 1'b1; in_instr = 32'h00F00193; in_pc = 32'h208;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready",   {31'd0, in_ready},  32'd0);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_pc",    out_pc,             32'h200);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_issue0_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_issue0_ready", {31'd0, in_ready},  32'd0);
    @(negedge clk);
    chk("bp_issue1_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_issue1_ready", {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin
      exp_t e;
      e.instr = 32'h00F00193; e.pc = 32'h208; e.imm = 32'hF;
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk("bp_issue2_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // Load-use: lw x5 then add x6,x5,x1 -> one bubble
    send(32'h00012283, 32'h300, 32'h0, 1'b1);
    send(32'h00128333, 32'h304, 32'h0, 1'b1);
    @(negedge clk);
    chk("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lu_after_valid",  {31'd0, out_valid}, 32'd1);
    chk("lu_bubble_count", {16'd0, bubble_count}, 32'd1);
    drain();

    // Independent consumer: no bubble
    send(32'h00012283, 32'h310, 32'h0, 1'b1);
    send(32'h00108333, 32'h314, 32'h0, 1'b1);
    @(negedge clk);
    chk("nolu_valid",        {31'd0, out_valid}, 32'd1);
    chk("nolu_bubble_count", {16'd0, bubble_count}, 32'd1);
    drain();

    // Load to x0: no bubble
    send(32'h00012003, 32'h320, 32'h0, 1'b1);
    send(32'h00000333, 32'h324, 32'h0, 1'b1);
    @(negedge clk);
    chk("x0_valid",        {31'd0, out_valid}, 32'd1);
    chk("x0_bubble_count", {16'd0, bubble_count}, 32'd1);
    drain();

    // Flush in TWO with a beat offered
    out_ready = 1'b0;
    send(32'h00500093, 32'h400, 32'h5, 1'b0);
    send(32'h00A00113, 32'h404, 32'hA, 1'b0);
    in_valid = 1'b1; in_instr = 32'h00F00193; in_pc = 32'h408; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    // Beat handshaken during a flush is dropped
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h40C; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_drop_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00A00113, 32'h410, 32'hA, 1'b1);
    drain();

    // Reset mid-stream with a load-use pending
    send(32'h00012283, 32'h500, 32'h0, 1'b1);
    send(32'h00128333, 32'h504, 32'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_out_valid",    {31'd0, out_valid},   32'd0);
    chk("mrst_in_ready",     {31'd0, in_ready},    32'd1);
    chk("mrst_out_pc",       out_pc,               32'd0);
    chk("mrst_out_imm",      out_imm,              32'd0);
    chk("mrst_out_opcode",   {25'd0, out_opcode},  32'd0);
    chk("mrst_out_rd",       {27'd0, out_rd},      32'd0);
    chk("mrst_out_rs1",      {27'd0, out_rs1},     32'd0);
    chk("mrst_out_rs2",      {27'd0, out_rs2},     32'd0);
    chk("mrst_out_is_load",  {31'd0, out_is_load}, 32'd0);
    chk("mrst_bubble_count", {16'd0, bubble_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'h00128333, 32'h508, 32'h0, 1'b1);
    @(negedge clk);
    chk("mrst_first_valid", {31'd0, out_valid}, 32'd1);
    drain();
    chk("final_bubble_count", {16'd0, bubble_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Decode/issue stage controller for the RV32 core. It accepts fetched instructions over a valid/ready handshake and buffers them in a two-entry skid register. Each instruction is decoded into register fields plus a sign-extended immediate (I/S/B/J formats), and the decoded bundle is issued to EX over a second valid/ready handshake. The block also inserts a one-cycle load-use bubble and supports pipeline flush.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating bubble counter.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock. One clock domain.
- `rst`, in, 1: reset. Synchronous, active-high.
- `flush`, in, 1: kill all buffered and incoming instructions (from branch resolve).
- `in_valid`, in, 1: fetch beat valid.
- `in_ready`, out, 1: block can accept a fetch beat.
- `in_instr`, in, 32: instruction word.
- `in_pc`, in, 32: PC of the instruction.
- `out_valid`, out, 1: decoded bundle valid.
- `out_ready`, in, 1: EX accepts the bundle.
- `out_pc`, out, 32: PC of the issued instruction.
- `out_opcode`, out, 7: `instr[6:0]`.
- `out_rd`, out, 5: `instr[11:7]`.
- `out_rs1`, out, 5: `instr[19:15]`.
- `out_rs2`, out, 5: `instr[24:20]`.
- `out_imm`, out, 32: sign-extended immediate.
- `out_is_load`, out, 1: opcode is 0000011.
- `bubble_count`, out, `CNT_W`: saturating count of forced bubble cycles.

## Operation
- **Immediate decode.** Computed from `in_instr` at capture time and stored with the entry:
  - 0000011 and 0010011: I-format, `{20{i[31]}, i[31:20]}`.
  - 0100011: S-format, `{20{i[31]}, i[31:25], i[11:7]}`.
  - 1100011: B-format, `{19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}`.
  - 1101111: J-format, `{11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}`.
  - Any other opcode: 0.
- **Source-register use.**
  - 0110011, 0100011, 1100011: use rs1 and rs2.
  - 0000011, 0010011: use rs1 only.
  - Any other opcode: uses none.
- **Buffer states.** Defined by main/skid valid bits: EMPTY, ONE, TWO.
  - `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
  - EMPTY: `in_fire` goes to ONE (load main).
  - ONE: `in_fire & out_fire` stays ONE (main replaced). `in_fire & !out_fire` goes to TWO (load skid). `!in_fire & out_fire` goes to EMPTY.
  - TWO: `out_fire` goes to ONE (skid moves to main).
  - Program order is always preserved.
- **`in_ready`** = skid entry empty. It is a register-only function.
- **Load-use tracking.**
  - On `out_fire` with `out_is_load=1` and `out_rd!=0`: set `lu_pending=1` and `lu_rd=out_rd`.
  - Otherwise `lu_pending` clears every cycle.
- **Bubble.**
  - Condition: `lu_pending`, main entry valid, and the main entry uses a source equal to `lu_rd`.
  - During a bubble, `out_valid=0` and the main entry is held.
  - `bubble_count` increments that cycle and saturates at all-ones.
- **Flush.**
  - At the next edge, both entries are invalidated and `lu_pending` clears.
  - A fetch beat handshaken in the flush cycle is dropped.
  - `bubble_count` is unaffected by flush.
- **Reset.**
  - Outputs: `out_valid=0`, `in_ready=1`, all `out_*` payload 0, `bubble_count=0`, `lu_pending=0`.
  - Reset mid-operation discards all entries; `rst` overrides `flush`.

## Timing
- Latency: `in_fire` at cycle t gives `out_valid=1` at t+1 (EMPTY, no bubble).
- Throughput: one instruction per cycle sustained with `out_ready=1`.
- No combinational path from `out_ready` or `in_valid` to `in_ready` or `out_valid`. Both are functions of registered state only.
- `out_*` payload is stable while `out_valid=1` and `out_ready=0`.
- A bubble lasts exactly one cycle (the cycle after the load issues). If the buffer is empty in that cycle, no bubble is counted.

## Test plan
- **Basic issue.** Reset, then push `0x00500093` (addi x1,x0,5) at pc `0x100` -> next cycle: `out_valid=1`, `out_imm=0x5`, `out_rd=1`, `out_rs1=0`, `out_pc=0x100`.
- **Immediates.** Push the following, expecting `out_imm`:
  - `0xFE000EE3` (beq -4) -> `0xFFFFFFFC`.
  - `0xFF9FF06F` (jal -8) -> `0xFFFFFFF8`.
  - `0xFE112E23` (sw x1,-4(x2)) -> `0xFFFFFFFC`.
  - `0x000010B7` (lui) -> `0x0`.
- **Backpressure.** Hold `out_ready=0` and offer 3 beats -> 2 accepted, `in_ready=0` after the second. Release `out_ready` -> the beats issue in order on consecutive cycles, none lost or duplicated.
- **Load-use.** With `out_ready=1`:
  - `0x00012283` (lw x5) then `0x00128333` (add x6,x5,x1) -> one cycle `out_valid=0` between them, `bubble_count=1`.
  - Repeat with `0x00108333` (add x6,x1,x1) -> no bubble.
  - A load with rd=x0 -> no bubble.
- **Flush.** In state TWO with `in_valid=1`, assert `flush` for one cycle -> next cycle `out_valid=0`, `in_ready=1`. The flush-cycle beat never appears on the output.
- **Reset mid-stream.** Assert `rst` while in TWO with `lu_pending=1` -> next cycle every output is at its reset value. The first beat after reset issues normally with no bubble.
